mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single RAM port between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Serialises accesses through a grant/wait/response state machine and latches the granted request onto the RAM port.
- Returns read data and a one-cycle ack to the winning requester.
- Drives stall_flag_o to ctrl while either requester is waiting.
- MEM has priority; a burst limit prevents IF starvation.

Parameters:
- ADDR_W, 64, address width of all address ports.
- DATA_W, 64, data width.
- MAX_MEM_BURST, 4, maximum consecutive MEM grants while IF is pending (≥1).
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- if_req_i  in  1  IF read request; held high until if_ack_o.
- if_addr_i  in  ADDR_W  IF address; stable while if_req_i is high.
- if_rdata_o  out  DATA_W  IF read data; valid while if_ack_o is high.
- if_ack_o  out  1  IF completion pulse.
- mem_req_i  in  1  MEM request; held high until mem_ack_o.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  ADDR_W  MEM address.
- mem_wdata_i  in  DATA_W  MEM write data.
- mem_wmask_i  in  8  byte-enable mask.
- mem_rdata_o  out  DATA_W  MEM read data.
- mem_ack_o  out  1  MEM completion pulse.
- ram_req_o  out  1  RAM request.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_wmask_o  out  8  RAM byte mask.
- ram_ack_i  in  1  RAM done; any latency ≥1 cycle after ram_req_o rises.
- ram_rdata_i  in  DATA_W  RAM read data; valid with ram_ack_i.
- stall_flag_o  out  3  bit0 = IF waiting, bit1 = MEM waiting, bit2 = 0 (reserved).
- err_o  out  1  timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0; burst counter 0; owner register cleared. Applies mid-transaction too: the RAM request is dropped with no ack, and any late ram_ack_i is ignored.
- States:
  - IDLE: arbitrate.
  - BUSY: ram_req_o held high, waiting for ram_ack_i.
  - RESP: one cycle, ack pulse to the owner.
- IDLE arbitration (registered grant):
  - MEM wins if mem_req_i is high, unless if_req_i is high and burst_cnt == MAX_MEM_BURST; then IF wins.
  - Otherwise IF wins if if_req_i is high.
  - On grant: latch addr, we, wdata and wmask (IF: we=0, wmask=0xFF, wdata=0) into the ram_* registers; record the owner; go to BUSY. ram_req_o is high from the next cycle.
- burst_cnt:
  - +1 on each MEM grant while if_req_i is high.
  - Cleared on an IF grant, or when if_req_i is low in IDLE.
  - Saturates at MAX_MEM_BURST.
- BUSY:
  - ram_* outputs stay constant.
  - On ram_ack_i: capture ram_rdata_i (writes capture 0) into the owner's rdata register; deassert ram_req_o and ram_we_o next cycle; go to RESP.
- RESP:
  - Owner's ack_o = 1 for exactly this cycle; its rdata_o is valid.
  - The non-owner's ack and rdata stay 0.
  - Next state IDLE.
- Post-ack masking: the requester acked in RESP is masked in the IDLE cycle that follows, so a req still high then does not regrant.
- Minimum access: 3 cycles (grant, BUSY with same-cycle-earliest ack, RESP). Back-to-back throughput: one access per 4 cycles when RAM acks after 1 cycle.
- stall_flag_o (combinational): bit0 = if_req_i & ~if_ack_o; bit1 = mem_req_i & ~mem_ack_o.
- rdata_o holds its value after RESP until the next ack for that requester.
- A requester changing addr or data while its req is high is illegal and unchecked.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY.
  - If it reaches TIMEOUT without ram_ack_i, go to RESP: ack the owner with rdata = 0, pulse err_o for one cycle, and drop ram_req_o.
  - A ram_ack_i arriving after the abort is ignored.
- Undefined: no counter; err_o is constant 0; BUSY waits indefinitely.

Test Plan:
1. IF-only read, if_addr_i=0x8000_0000; RAM acks 2 cycles after ram_req_o rises with 0x0000_0413_0000_0297 -> ram_addr_o=0x8000_0000, ram_we_o=0, ram_wmask_o=0xFF; if_ack_o pulses 1 cycle after ram_ack_i with that data; stall_flag_o=3'b001 until the ack.
2. IF and MEM requests in the same IDLE cycle (MEM read 0x8000_1000) -> MEM granted first and acked; IF granted in the following IDLE; stall_flag_o=3'b011 at the start.
3. MEM write, addr 0x8000_2008, wdata 0xDEAD_BEEF_CAFE_F00D, wmask 0x0F -> ram_we_o=1, ram_wmask_o=0x0F, mem_ack_o pulses, mem_rdata_o=0.
4. MEM req held continuously plus IF req, MAX_MEM_BURST=4 -> exactly 4 MEM grants, then an IF grant, then MEM resumes.
5. rst low during BUSY, then ram_ack_i arrives after release -> all outputs 0, no ack pulse, state IDLE.
6. ARB_TIMEOUT_EN defined, TIMEOUT=8, RAM never acks -> after 8 BUSY cycles err_o and owner ack pulse together with rdata=0; ram_req_o low next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one RAM port between instruction fetch (IF, read-only) and the MEM
// stage (load/store). An IDLE/BUSY/RESP state machine picks one requester,
// latches its request onto the ram_* registers, waits for the RAM to finish,
// then pulses a one-cycle ack with the read data back to that requester.
//
// Handshake: a requester raises *_req_i and holds it, with stable address and
// data, until it sees its *_ack_o pulse; rdata_o is valid in the ack cycle and
// is held until that requester's next ack. Towards the RAM, ram_req_o and the
// ram_* fields stay constant from the cycle after the grant until ram_ack_i is
// sampled high; ram_rdata_i is taken in that same cycle.
//
// Arbitration: MEM wins unless IF is waiting and MEM has already taken
// MAX_MEM_BURST grants in a row while IF waited. The requester acked in RESP
// is masked in the IDLE cycle that follows: if it would win that cycle,
// nothing is granted.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - a BUSY watchdog aborts after TIMEOUT cycles without ram_ack_i,
//               acks the owner with rdata 0 and pulses err_o.
//   undefined - BUSY waits indefinitely, err_o is constant 0.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   if_req_i/if_addr_i   IF read request and address
//   if_rdata_o/if_ack_o  IF read data and completion pulse
//   mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i
//                        MEM request, write enable, address, data, byte mask
//   mem_rdata_o/mem_ack_o MEM read data and completion pulse
//   ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o
//                        registered RAM request fields
//   ram_ack_i/ram_rdata_i RAM completion and read data
//   stall_flag_o         bit0 IF waiting, bit1 MEM waiting, bit2 reserved 0
//   err_o                watchdog timeout pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_MEM_BURST = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [7:0]        mem_wmask_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [7:0]        ram_wmask_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [2:0]        stall_flag_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(MAX_MEM_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_MEM_BURST);

  state_t           state;
  logic             owner_mem;   // 1: current access belongs to MEM
  logic             mask_if;     // IF was acked last cycle
  logic             mask_mem;    // MEM was acked last cycle
  logic [CNT_W-1:0] burst_cnt;   // MEM grants taken while IF waited
  logic             timeout_hit;

  logic burst_full;
  logic mem_win;
  logic if_win;
  logic grant_mem;
  logic grant_if;
  logic [DATA_W-1:0] resp_data;

  // Winner is chosen by priority first; the post-ack mask then only vetoes,
  // so a masked MEM does not hand its slot to IF before the burst limit.
  always_comb begin
    burst_full = if_req_i && (burst_cnt == BURST_MAX);
    mem_win    = mem_req_i && !burst_full;
    if_win     = if_req_i && !mem_win;
    grant_mem  = mem_win && !mask_mem;
    grant_if   = if_win && !mask_if;
    // Writes and watchdog aborts return zero data.
    resp_data  = (ram_ack_i && !ram_we_o) ? ram_rdata_i : '0;
  end

  assign stall_flag_o = {1'b0, mem_req_i & ~mem_ack_o, if_req_i & ~if_ack_o};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      owner_mem   <= 1'b0;
      mask_if     <= 1'b0;
      mask_mem    <= 1'b0;
      burst_cnt   <= '0;
      ram_req_o   <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_wmask_o <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      mask_if   <= 1'b0;
      mask_mem  <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req_i) burst_cnt <= '0;
          if (grant_mem) begin
            ram_req_o   <= 1'b1;
            ram_we_o    <= mem_we_i;
            ram_addr_o  <= mem_addr_i;
            ram_wdata_o <= mem_wdata_i;
            ram_wmask_o <= mem_wmask_i;
            owner_mem   <= 1'b1;
            state       <= BUSY;
            if (if_req_i && (burst_cnt != BURST_MAX)) burst_cnt <= burst_cnt + 1'b1;
          end else if (grant_if) begin
            ram_req_o   <= 1'b1;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= if_addr_i;
            ram_wdata_o <= '0;
            ram_wmask_o <= 8'hFF;
            owner_mem   <= 1'b0;
            burst_cnt   <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (ram_ack_i || timeout_hit) begin
            ram_req_o <= 1'b0;
            ram_we_o  <= 1'b0;
            state     <= RESP;
            if (owner_mem) begin
              mem_ack_o   <= 1'b1;
              mem_rdata_o <= resp_data;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= resp_data;
            end
          end
        end
        RESP: begin
          mask_mem <= owner_mem;
          mask_if  <= !owner_mem;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] busy_cnt;

  // busy_cnt counts completed BUSY cycles; the TIMEOUT-th one aborts.
  assign timeout_hit = (busy_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= (state == BUSY) && !ram_ack_i && timeout_hit;
      if (state == BUSY) busy_cnt <= busy_cnt + 1'b1;
      else               busy_cnt <= '0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Random IF/MEM requesters and a random-latency RAM drive the arbiter. A
// transaction-level reference model tracks which access is in flight, when it
// completes (from the RAM ack the bench itself drives), the arbitration rules
// and the data each requester must receive. Read data returned by the RAM is
// a fixed function of the address, so expected data comes from the requested
// address alone. Define ARB_TIMEOUT_EN to also exercise the watchdog
// (TIMEOUT = 8, RAM occasionally never answers).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int MAXB  = 4;
  localparam int N_CYC = 6000;
`ifdef ARB_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [7:0]    mem_wmask_i;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_ack_o;
  logic          ram_req_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [7:0]    ram_wmask_o;
  logic          ram_ack_i;
  logic [DW-1:0] ram_rdata_i;
  logic [2:0]    stall_flag_o;
  logic          err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_MEM_BURST(MAXB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
    .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i),
    .stall_flag_o(stall_flag_o), .err_o(err_o)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Content the bench RAM returns for an address.
  function automatic logic [63:0] ram_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_A5A5, a[63:32] + 32'h1357_9BDF};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  int          n = 0;          // posedge index
  bit          act = 1'b0;     // an access is in flight
  int          g = 0;          // edge of its grant
  bit          own_mem = 1'b0;
  logic [63:0] t_addr, t_wdata;
  logic        t_we;
  logic [7:0]  t_wmask;
  int          free_at = 0;    // first edge at which arbitration may happen
  int          mask_edge = -1; // edge at which the last acked requester is masked
  bit          mask_who_mem = 1'b0;
  int          cnt = 0;        // MEM grants in a row while IF waited
  bit          e_if_ack, e_mem_ack, e_err, zero_ram;
  logic [63:0] e_if_rdata, e_mem_rdata;
  logic [63:0] exp_q[$];       // expected read data of the access in flight

  task automatic model_edge();
    e_if_ack  = 1'b0;
    e_mem_ack = 1'b0;
    e_err     = 1'b0;
    if (!rst) begin
      act = 1'b0; cnt = 0; free_at = n + 1; mask_edge = -1;
      e_if_rdata = '0; e_mem_rdata = '0; zero_ram = 1'b1;
      exp_q.delete();
    end else if (act) begin
      bit done;
      bit to;
      done = 1'b0;
      to   = 1'b0;
      if (ram_ack_i && n > g) done = 1'b1;
      else if (TO_EN && (n - g) == TO) begin done = 1'b1; to = 1'b1; end
      if (done) begin
        logic [63:0] d;
        d = exp_q.pop_front();
        if (to) d = '0;
        if (own_mem) begin e_mem_ack = 1'b1; e_mem_rdata = d; end
        else begin e_if_ack = 1'b1; e_if_rdata = d; end
        e_err = to;
        act = 1'b0;
        free_at = n + 2;
        mask_edge = n + 2;
        mask_who_mem = own_mem;
      end
    end else if (n >= free_at) begin
      bit mem_w;
      bit if_w;
      bit masked;
      mem_w  = mem_req_i && !(if_req_i && cnt == MAXB);
      if_w   = !mem_w && if_req_i;
      masked = (n == mask_edge) && ((mem_w && mask_who_mem) || (if_w && !mask_who_mem));
      if (!if_req_i) cnt = 0;
      if (!masked && mem_w) begin
        act = 1'b1; g = n; own_mem = 1'b1; zero_ram = 1'b0;
        t_addr = mem_addr_i; t_we = mem_we_i; t_wdata = mem_wdata_i; t_wmask = mem_wmask_i;
        exp_q.push_back(mem_we_i ? 64'd0 : ram_word(mem_addr_i));
        if (if_req_i) cnt = (cnt < MAXB) ? cnt + 1 : MAXB;
      end else if (!masked && if_w) begin
        act = 1'b1; g = n; own_mem = 1'b0; zero_ram = 1'b0;
        t_addr = if_addr_i; t_we = 1'b0; t_wdata = '0; t_wmask = 8'hFF;
        exp_q.push_back(ram_word(if_addr_i));
        cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("ram_req", ram_req_o, act);
    check("ram_we", ram_we_o, act ? t_we : 1'b0);
    if (act) begin
      check("ram_addr", ram_addr_o, t_addr);
      check("ram_wdata", ram_wdata_o, t_wdata);
      check("ram_wmask", ram_wmask_o, t_wmask);
    end else if (zero_ram) begin
      check("ram_addr_rst", ram_addr_o, 64'd0);
      check("ram_wdata_rst", ram_wdata_o, 64'd0);
      check("ram_wmask_rst", ram_wmask_o, 64'd0);
    end
    check("if_ack", if_ack_o, e_if_ack);
    check("mem_ack", mem_ack_o, e_mem_ack);
    check("if_rdata", if_rdata_o, e_if_rdata);
    check("mem_rdata", mem_rdata_o, e_mem_rdata);
    check("err", err_o, e_err);
  endtask

  task automatic check_stall();
    logic [2:0] s;
    s = {1'b0, mem_req_i & ~e_mem_ack, if_req_i & ~e_if_ack};
    check("stall_flag", stall_flag_o, s);
  endtask

  // ---------------- driver tasks ----------------
  int cd = -1;        // RAM ack countdown, -1 when idle
  bit silent = 1'b0;  // RAM ignores the current request
  int rst_hold = 3;

  task automatic drive_reset();
    if (rst_hold > 0) begin
      rst = 1'b0;
      rst_hold--;
    end else begin
      rst = 1'b1;
      if (n > 20 && $urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        rst_hold = $urandom_range(0, 1);
      end
    end
  endtask

  task automatic drive_requesters();
    if (e_if_ack) if_req_i = 1'b0;
    if (!if_req_i && $urandom_range(0, 3) == 0) begin
      if_req_i  = 1'b1;
      if_addr_i = rand64();
    end
    if (e_mem_ack) mem_req_i = 1'b0;
    if (!mem_req_i && $urandom_range(0, 3) != 0) begin
      mem_req_i   = 1'b1;
      mem_we_i    = 1'($urandom_range(0, 1));
      mem_addr_i  = rand64();
      mem_wdata_i = rand64();
      mem_wmask_i = 8'($urandom_range(0, 255));
    end
  endtask

  // RAM: answers 1..4 cycles after seeing its request; the countdown is not
  // cleared by reset, so late acks after a reset occur naturally.
  task automatic drive_ram();
    ram_ack_i   = 1'b0;
    ram_rdata_i = rand64();
    if (!ram_req_o) silent = 1'b0;
    if (cd < 0 && ram_req_o && !silent) begin
      if (TO_EN && $urandom_range(0, 7) == 0) silent = 1'b1;
      else cd = $urandom_range(0, 3);
    end
    if (cd == 0) begin
      ram_ack_i   = 1'b1;
      ram_rdata_i = ram_word(ram_addr_o);
      cd = -1;
    end else if (cd > 0) begin
      cd--;
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_wmask_i = '0;
    ram_ack_i = 1'b0; ram_rdata_i = '0;
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      n++;
      model_edge();
      #1;
      check_outputs();
      drive_reset();
      drive_requesters();
      drive_ram();
      #1;
      check_stall();
    end
    check("exp_q_depth", 64'(exp_q.size()), act ? 64'd1 : 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
